// File: rtl/pe_pkg.sv
// Shared definitions for the 4:2 priority encoder request path.
// Provides the request/index widths, the arbiter state type and the
// highest-index priority encoder used both here and by the downstream stage.
package pe_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } state_e;

  // Encoder result: any = at least one input bit set, idx = highest set bit.
  typedef struct packed {
    logic            any;
    logic [IDXW-1:0] idx;
  } enc_t;

  // Highest index wins (bit 3 > bit 2 > bit 1 > bit 0); idx is 0 when no bit is set.
  function automatic enc_t prio_enc4(input logic [NREQ-1:0] bits);
    enc_t r;
    r.any = |bits;
    if (bits[3]) begin
      r.idx = 2'd3;
    end else if (bits[2]) begin
      r.idx = 2'd2;
    end else if (bits[1]) begin
      r.idx = 2'd1;
    end else begin
      r.idx = 2'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_req_arbiter.sv
// Request capture and arbitration stage in front of the 4:2 priority encoder.
// Rising edges on req set sticky pending bits; the highest pending index is
// presented to the consumer with a valid/ready handshake, and edges that hit an
// already-pending line are counted in a saturating miss counter.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset
//   req        request lines (level; a rising edge raises a request)
//   out_idx    index of the presented grant, held while out_valid is low
//   out_valid  out_idx is valid
//   out_ready  consumer accepts out_idx when out_valid and out_ready are high
//   pending    current sticky pending bits
//   miss_cnt   saturating count of edges dropped on already-pending lines
module pe_req_arbiter
  import pe_pkg::*;
#(
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [IDXW-1:0] out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NREQ-1:0] pending,
  output logic [CNTW-1:0] miss_cnt
);

  // Headroom so adding up to NREQ misses cannot wrap before the saturation test.
  localparam int unsigned SumW = CNTW + 3;

  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] clr;
  logic [NREQ-1:0] miss_vec;
  logic            handshake;
  logic [2:0]      miss_num;
  logic [SumW-1:0] cnt_sum;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  state_e          state_q, state_d;
  enc_t            enc;

  // Edge detect, pending update and miss accounting.
  always_comb begin
    rise      = req & ~req_q;
    handshake = (state_q == StPresent) & out_ready;
    clr       = '0;
    if (handshake) begin
      clr[idx_q] = 1'b1;
    end
    // Set has priority over clear on the same line.
    pend_d   = (pend_q & ~clr) | rise;
    // A line being cleared this cycle can take a fresh edge without a miss.
    miss_vec = rise & pend_q & ~clr;

    miss_num = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      miss_num = miss_num + {2'b00, miss_vec[i]};
    end

    cnt_sum = {3'b000, cnt_q} + {{(SumW - 3){1'b0}}, miss_num};
    if (cnt_sum > {3'b000, {CNTW{1'b1}}}) begin
      cnt_d = {CNTW{1'b1}};
    end else begin
      cnt_d = cnt_sum[CNTW-1:0];
    end
  end

  // Grant FSM: the index is sampled only from IDLE so it stays stable under
  // backpressure, and every grant is followed by one IDLE bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    enc     = prio_enc4(pend_q);
    unique case (state_q)
      StIdle: begin
        if (enc.any) begin
          idx_d   = enc.idx;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // req_q also loads during reset so a level held through reset is not an edge.
    req_q <= req;
    if (rst) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= StIdle;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign out_valid = (state_q == StPresent);
  assign out_idx   = idx_q;
  assign pending   = pend_q;
  assign miss_cnt  = cnt_q;

endmodule

// File: tb/tb_pe_req_arbiter.sv
// Bench for pe_req_arbiter: a directed vector table, hand-written corner
// sequences and a random phase, all compared against a behavioural model.
// A second instance with a 2-bit miss counter exercises saturation.
module tb_pe_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] out_idx, out_idx2;
  logic       out_valid, out_valid2;
  logic [3:0] pending, pending2;
  logic [7:0] miss_cnt;
  logic [1:0] miss_cnt2;

  always #5 clk = ~clk;

  pe_req_arbiter #(.CNTW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending),
    .miss_cnt (miss_cnt)
  );

  pe_req_arbiter #(.CNTW(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .out_idx  (out_idx2),
    .out_valid(out_valid2),
    .out_ready(out_ready),
    .pending  (pending2),
    .miss_cnt (miss_cnt2)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_pend[4];
  int m_prev[4];
  int m_busy;
  int m_idx;
  int m_miss;
  int m_miss2;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] pend;
    logic [7:0] miss;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pend_bits();
    int v = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i] != 0) v += (1 << i);
    end
    return v;
  endfunction

  // One clock edge of the arbiter's rules applied to the current inputs.
  task automatic model_step();
    int old_pend[4];
    int any_old;
    int cleared;
    int misses;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_prev[i] = int'(req[i]);
      end
      m_busy  = 0;
      m_idx   = 0;
      m_miss  = 0;
      m_miss2 = 0;
      return;
    end
    any_old = 0;
    for (int i = 0; i < 4; i++) begin
      old_pend[i] = m_pend[i];
      if (m_pend[i] != 0) any_old = 1;
    end
    cleared = (m_busy != 0 && out_ready) ? m_idx : -1;
    misses = 0;
    for (int i = 0; i < 4; i++) begin
      int edge_seen;
      edge_seen = (req[i] && m_prev[i] == 0) ? 1 : 0;
      if (edge_seen != 0 && old_pend[i] != 0 && i != cleared) misses++;
      if (i == cleared) m_pend[i] = 0;
      if (edge_seen != 0) m_pend[i] = 1;
      m_prev[i] = int'(req[i]);
    end
    m_miss  = (m_miss + misses > 255) ? 255 : m_miss + misses;
    m_miss2 = (m_miss2 + misses > 3) ? 3 : m_miss2 + misses;
    if (m_busy != 0) begin
      if (out_ready) m_busy = 0;
    end else if (any_old != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (old_pend[i] != 0) m_idx = i;
      end
      m_busy = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_valid", out_valid, m_busy);
    check("model_idx", out_idx, m_idx);
    check("model_pending", pending, model_pend_bits());
    check("model_miss", miss_cnt, m_miss);
    check("model_miss_sat", miss_cnt2, m_miss2);
    check("model_valid_w2", out_valid2, m_busy);
    check("model_pending_w2", pending2, model_pend_bits());
  endtask

  task automatic drain();
    req       = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask

  int miss_base;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_busy = 0; m_idx = 0; m_miss = 0; m_miss2 = 0;
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;

    // Single request, then simultaneous requests with ready tied high.
    //          rst   req      rdy   idx    valid pend     miss
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 8'd0};
    vecs[1]  = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 4'b0001, 8'd0};
    vecs[2]  = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 8'd0};
    vecs[3]  = '{1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0000, 8'd0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 8'd0};
    vecs[5]  = '{1'b0, 4'b1010, 1'b1, 2'd0, 1'b0, 4'b1010, 8'd0};
    vecs[6]  = '{1'b0, 4'b1010, 1'b1, 2'd3, 1'b1, 4'b1010, 8'd0};
    vecs[7]  = '{1'b0, 4'b1010, 1'b1, 2'd3, 1'b0, 4'b0010, 8'd0};
    vecs[8]  = '{1'b0, 4'b1010, 1'b1, 2'd1, 1'b1, 4'b0010, 8'd0};
    vecs[9]  = '{1'b0, 4'b1010, 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0};

    for (int v = 0; v < 11; v++) begin
      rst       = vecs[v].rst;
      req       = vecs[v].req;
      out_ready = vecs[v].rdy;
      tick();
      check($sformatf("vec%0d_idx", v), out_idx, vecs[v].idx);
      check($sformatf("vec%0d_valid", v), out_valid, vecs[v].valid);
      check($sformatf("vec%0d_pending", v), pending, vecs[v].pend);
      check($sformatf("vec%0d_miss", v), miss_cnt, vecs[v].miss);
    end

    // Backpressure: index stays 0 while a higher request arrives.
    out_ready = 1'b0;
    req = 4'b0001; tick();
    check("bp_pending", pending, 4'b0001);
    tick();
    check("bp_valid", out_valid, 1'b1);
    req = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_idx%0d", i), out_idx, 2'd0);
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1; tick();
    check("bp_hs_pending", pending, 4'b0100);
    check("bp_hs_valid", out_valid, 1'b0);
    out_ready = 1'b0; tick();
    check("bp_next_idx", out_idx, 2'd2);
    check("bp_next_valid", out_valid, 1'b1);
    out_ready = 1'b1; tick();
    check("bp_done_pending", pending, 4'b0000);
    drain();

    // Set wins: a fresh edge on the line being handshaken keeps it pending.
    miss_base = int'(miss_cnt);
    out_ready = 1'b0;
    req = 4'b0010; tick();
    tick();
    check("sw_idx", out_idx, 2'd1);
    req = 4'b0000; tick();
    req = 4'b0010; out_ready = 1'b1; tick();
    check("sw_pending", pending, 4'b0010);
    check("sw_valid", out_valid, 1'b0);
    check("sw_miss", miss_cnt, miss_base);
    out_ready = 1'b0; tick();
    check("sw_again_valid", out_valid, 1'b1);
    check("sw_again_idx", out_idx, 2'd1);
    drain();

    // Misses and saturation of the 2-bit counter.
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      req = 4'b0001; tick();
      req = 4'b0000; tick();
    end
    check("miss_three_pulses", miss_cnt, 8'd2);
    check("miss_three_pulses_w2", miss_cnt2, 2'd2);
    for (int p = 0; p < 2; p++) begin
      req = 4'b0001; tick();
      req = 4'b0000; tick();
    end
    check("miss_five_pulses", miss_cnt, 8'd4);
    check("miss_sat_w2", miss_cnt2, 2'd3);
    drain();

    // Reset in the middle of a presented grant.
    out_ready = 1'b0;
    req = 4'b1100; tick();
    tick();
    check("rst_pre_valid", out_valid, 1'b1);
    check("rst_pre_pending", pending, 4'b1100);
    req = 4'b0100; rst = 1'b1; tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_pending", pending, 4'b0000);
    check("rst_miss", miss_cnt, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_after_valid%0d", i), out_valid, 1'b0);
      check($sformatf("rst_after_pending%0d", i), pending, 4'b0000);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      req       = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
